// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   CNT_W_DEF / DEFAULT_DIV_DEF : default counter width and reset divide ratio
//   cfg_req_t                   : a captured configuration request (channel, ratio)
//   lock_state_e                : per-channel lock progress, exported for debug
// The request struct is sized for the largest legal build (16 channels,
// 32-bit ratios). The top level zero-extends into it and narrows back out of it.
package clk_div_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int DEFAULT_DIV_DEF = 2;
  localparam int CFG_CH_W        = 4;   // holds channel numbers 0..15
  localparam int CFG_DIV_W       = 32;  // holds any ratio with CNT_W <= 32

  typedef struct packed {
    logic [CFG_CH_W-1:0]  ch;
    logic [CFG_DIV_W-1:0] div;
  } cfg_req_t;

  // LS_WAIT_APPLY : a new ratio is accepted but not yet loaded into the counter
  // LS_ARMED      : a ratio is loaded, and its first strobe has not been output yet
  // LS_LOCKED     : the loaded ratio has produced at least one strobe
  typedef enum logic [1:0] {
    LS_WAIT_APPLY = 2'd0,
    LS_ARMED      = 2'd1,
    LS_LOCKED     = 2'd2
  } lock_state_e;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel. It holds the ratio register, the phase counter, the
// registered strobe and square-wave outputs, and the lock-progress FSM.
//   clk_in, rst_n : source clock, async active-low reset
//   sync          : restart the counter at 0 on the next edge
//   accept        : a new request for this channel is being accepted this cycle
//   pend_hit      : a previously accepted request targets this channel
//   new_div       : ratio of that pending request
//   apply         : (comb) the pending ratio is loaded at this edge
//   clk_en        : one-cycle strobe per divided period
//   clk_out       : divided square wave (high for ceil(div/2) cycles)
//   lock_state    : lock FSM state; locked == (lock_state == LS_LOCKED)
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sync,
  input  logic             accept,
  input  logic             pend_hit,
  input  logic [CNT_W-1:0] new_div,
  output logic             apply,
  output logic             clk_en,
  output logic             clk_out,
  output lock_state_e      lock_state
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half;
  logic             wrap;
  logic             out_d;
  lock_state_e      state_d;

  assign wrap = (cnt_q == div_q - ONE);
  // ceil(div/2), written so it cannot overflow for an all-ones ratio
  assign half = (div_q >> 1) + {{(CNT_W-1){1'b0}}, div_q[0]};
  // A ratio of 1 has no low phase to show, so the wave is held low
  assign out_d = (div_q != ONE) && (cnt_q < half);

  always_comb begin
    apply   = pend_hit && (sync || wrap);
    cnt_d   = (sync || wrap) ? '0 : cnt_q + ONE;
    div_d   = apply ? new_div : div_q;
    state_d = lock_state;
    if (accept) begin
      state_d = LS_WAIT_APPLY;
    end else if (apply) begin
      state_d = LS_ARMED;
    end else if (lock_state == LS_ARMED && wrap) begin
      // This wrap is the first one of the loaded ratio, so its strobe is
      // output at the same edge that sets locked.
      state_d = LS_LOCKED;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= CNT_W'(DEFAULT_DIV);
      cnt_q      <= '0;
      clk_en     <= 1'b0;
      clk_out    <= 1'b0;
      lock_state <= LS_ARMED;
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      clk_en     <= wrap;
      clk_out    <= out_d;
      lock_state <= state_d;
    end
  end

endmodule

// File: rtl/multi_clock_divider.sv
// Multi-channel clock divider. It generates NUM_CH strobe/square-wave pairs
// from clk_in, and each channel's ratio can be changed at run time without a
// short or glitched period.
//   clk_in, rst_n      : source clock, async active-low reset
//   cfg_valid/cfg_ready: request handshake, with target cfg_ch and ratio cfg_div
//   cfg_err            : one-cycle pulse after a rejected request
//   sync               : restart every channel counter in phase
//   clk_en[i]          : per-channel one-cycle strobe per divided period
//   clk_out[i]         : per-channel registered divided square wave
//   locked[i]          : channel is running a fully applied ratio
//
// Handshake: a request is taken when cfg_valid && cfg_ready are both high at a
// rising edge. If the request is illegal (cfg_div == 0 or cfg_ch >= NUM_CH),
// cfg_err pulses for the next cycle and nothing else changes. Otherwise the
// request is held pending, and cfg_ready stays low until the target channel
// loads the new ratio. It loads at that channel's next wrap, or at a sync
// that arrives after the request was taken. cfg_valid may stay high while
// cfg_ready is low. It is only sampled when cfg_ready is high.
module multi_clock_divider
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int CNT_W       = CNT_W_DEF,
  parameter  int DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] locked
);

  cfg_req_t          pend_q;
  cfg_req_t          req_in;
  logic              pend_valid_q;
  logic              cfg_take;
  logic              cfg_bad;
  logic              cfg_accept;
  logic [NUM_CH-1:0] apply_vec;
  logic [CNT_W-1:0]  pend_div;

  assign cfg_ready  = ~pend_valid_q;
  assign cfg_take   = cfg_valid & cfg_ready;
  assign cfg_bad    = (cfg_div == '0) || (32'(cfg_ch) >= 32'(NUM_CH));
  assign cfg_accept = cfg_take & ~cfg_bad;
  assign pend_div   = CNT_W'(pend_q.div);

  always_comb begin
    req_in     = '0;
    req_in.ch  = CFG_CH_W'(cfg_ch);
    req_in.div = CFG_DIV_W'(cfg_div);
  end

  // Acceptance requires no pending request, and loading requires one, so the
  // two branches below never compete.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_err <= cfg_take & cfg_bad;
      if (cfg_accept) begin
        pend_valid_q <= 1'b1;
        pend_q       <= req_in;
      end else if (|apply_vec) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic        pend_hit;
    logic        accept_i;
    lock_state_e state;

    assign pend_hit  = pend_valid_q && (pend_q.ch == CFG_CH_W'(i));
    assign accept_i  = cfg_accept && (32'(cfg_ch) == 32'(i));
    assign locked[i] = (state == LS_LOCKED);

    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .sync       (sync),
      .accept     (accept_i),
      .pend_hit   (pend_hit),
      .new_div    (pend_div),
      .apply      (apply_vec[i]),
      .clk_en     (clk_en[i]),
      .clk_out    (clk_out[i]),
      .lock_state (state)
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Bench for multi_clock_divider. Five channels are used so that a 3-bit
// channel field can carry out-of-range numbers such as 5 and 7.
// Each cycle a reference model predicts every output. The model works from
// the cycle number at which each channel last restarted, using
// cnt = (t - origin) % div. The predictions go into an expected queue and are
// compared one cycle later. Table-driven and hand-written sequences check
// periods, duty cycles, sync alignment, rejection and reset directly.
module tb_multi_clock_divider;

  localparam int NCH   = 5;
  localparam int CW    = 16;
  localparam int DDIV  = 2;
  localparam int CHW   = $clog2(NCH);
  localparam int EXP_W = 3 * NCH + 2;

  // ---------------- clock / reset ----------------
  logic           clk_in = 1'b0;
  logic           rst_n;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           cfg_err;
  logic           sync;
  logic [NCH-1:0] clk_en;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] locked;

  always #5 clk_in = ~clk_in;

  multi_clock_divider #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .DEFAULT_DIV (DDIV)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .sync      (sync),
    .clk_en    (clk_en),
    .clk_out   (clk_out),
    .locked    (locked)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_t;
  int m_div[NCH];
  int m_org[NCH];     // cycle at which the channel's count was last 0
  bit m_lock[NCH];
  bit m_armed[NCH];   // a new ratio is loaded and its first strobe is still to come
  bit mp_valid;
  int mp_ch;
  int mp_div;

  function automatic void model_reset();
    m_t = 0;
    for (int i = 0; i < NCH; i++) begin
      m_div[i]   = DDIV;
      m_org[i]   = 0;
      m_lock[i]  = 1'b0;
      m_armed[i] = 1'b1;
    end
    mp_valid = 1'b0;
    exp_q.delete();
  endfunction

  // Uses the inputs present in the current cycle to predict the outputs after
  // the next rising edge.
  function automatic void model_step();
    int c;
    int d;
    int cnt;
    bit wrap[NCH];
    bit take;
    bit illegal;
    logic [NCH-1:0] e_en;
    logic [NCH-1:0] e_out;
    logic [NCH-1:0] e_lock;
    c = int'(cfg_ch);
    d = int'(cfg_div);
    for (int i = 0; i < NCH; i++) begin
      cnt      = (m_t - m_org[i]) % m_div[i];
      wrap[i]  = (cnt == m_div[i] - 1);
      e_en[i]  = wrap[i];
      e_out[i] = (m_div[i] > 1) && (cnt < (m_div[i] + 1) / 2);
    end
    take    = cfg_valid && !mp_valid;
    illegal = (d == 0) || (c >= NCH);
    for (int i = 0; i < NCH; i++) begin
      if (m_armed[i] && wrap[i]) begin
        m_lock[i]  = 1'b1;
        m_armed[i] = 1'b0;
      end
    end
    if (mp_valid && (sync || wrap[mp_ch])) begin
      m_div[mp_ch]   = mp_div;
      m_armed[mp_ch] = 1'b1;
      mp_valid       = 1'b0;
    end
    for (int i = 0; i < NCH; i++) begin
      if (sync || wrap[i]) m_org[i] = m_t + 1;
    end
    if (take && !illegal) begin
      mp_valid   = 1'b1;
      mp_ch      = c;
      mp_div     = d;
      m_lock[c]  = 1'b0;
      m_armed[c] = 1'b0;
    end
    m_t++;
    for (int i = 0; i < NCH; i++) e_lock[i] = m_lock[i];
    exp_q.push_back({!mp_valid, take && illegal, e_lock, e_out, e_en});
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs are driven 1 time unit after a rising edge; one call = one cycle.
  task automatic tick();
    logic [EXP_W-1:0] e;
    model_step();
    @(posedge clk_in);
    #1;
    e = exp_q.pop_front();
    check("clk_en",    32'(clk_en),    32'(e[NCH-1:0]));
    check("clk_out",   32'(clk_out),   32'(e[2*NCH-1:NCH]));
    check("locked",    32'(locked),    32'(e[3*NCH-1:2*NCH]));
    check("cfg_err",   32'(cfg_err),   32'(e[3*NCH]));
    check("cfg_ready", 32'(cfg_ready), 32'(e[3*NCH+1]));
  endtask

  task automatic check_defaults(input string tag);
    check({tag, "_clk_en"},    32'(clk_en),    32'd0);
    check({tag, "_clk_out"},   32'(clk_out),   32'd0);
    check({tag, "_locked"},    32'(locked),    32'd0);
    check({tag, "_cfg_err"},   32'(cfg_err),   32'd0);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
  endtask

  // Asserts reset between edges, checks the outputs at once, then releases
  // reset just after a rising edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check_defaults(tag);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!cfg_ready && g < 200) begin
      tick();
      g++;
    end
    check("wait_cfg_ready", 32'(cfg_ready), 32'd1);
  endtask

  task automatic send_cfg(input int ch, input int dv);
    wait_ready();
    cfg_valid = 1'b1;
    cfg_ch    = CHW'(ch);
    cfg_div   = CW'(dv);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_lock(input int ch);
    int g = 0;
    while (!locked[ch] && g < 100) begin
      tick();
      g++;
    end
    check("wait_locked", 32'(locked[ch]), 32'd1);
  endtask

  // ---------------- test ----------------
  typedef struct {
    int ch;
    int dv;
    int period;
    int high;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n_en;
    int n_hi;
    int first0;
    int first2;
    int first_both;
    int n_both;
    int k;

    vecs = '{'{1, 5, 5, 3}, '{0, 3, 3, 2}, '{2, 4, 4, 2},
             '{3, 1, 1, 0}, '{4, 2, 2, 1}, '{1, 7, 7, 4}};

    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    sync      = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check_defaults("reset");
    rst_n = 1'b1;
    model_reset();

    // Defaults: each channel strobes every 2 cycles and locks at its first strobe.
    repeat (8) tick();
    check("default_locked", 32'(locked), 32'h1f);

    // Table: change a ratio, wait for lock, then count over four whole periods.
    foreach (vecs[v]) begin
      send_cfg(vecs[v].ch, vecs[v].dv);
      check("accept_ready_low", 32'(cfg_ready), 32'd0);
      wait_lock(vecs[v].ch);
      n_en = 0;
      n_hi = 0;
      for (int j = 0; j < 4 * vecs[v].period; j++) begin
        tick();
        n_en += int'(clk_en[vecs[v].ch]);
        n_hi += int'(clk_out[vecs[v].ch]);
      end
      check("tbl_strobes", 32'(n_en), 32'd4);
      check("tbl_high",    32'(n_hi), 32'(4 * vecs[v].high));
    end

    // Illegal requests: zero ratio, then out-of-range channels.
    send_cfg(2, 0);
    check("rej_div0_err",   32'(cfg_err),   32'd1);
    check("rej_div0_ready", 32'(cfg_ready), 32'd1);
    send_cfg(7, 3);
    check("rej_ch7_err",    32'(cfg_err),   32'd1);
    check("rej_ch7_ready",  32'(cfg_ready), 32'd1);
    send_cfg(5, 3);
    check("rej_ch5_err",    32'(cfg_err),   32'd1);
    tick();
    check("rej_err_pulse",  32'(cfg_err),   32'd0);

    // Sync alignment: ch0 div 3 and ch2 div 4 strobe together every 12 cycles.
    send_cfg(0, 3);
    send_cfg(2, 4);
    wait_ready();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    first0     = 0;
    first2     = 0;
    first_both = 0;
    n_both     = 0;
    for (int j = 1; j <= 24; j++) begin
      tick();
      if (clk_en[0] && first0 == 0) first0 = j;
      if (clk_en[2] && first2 == 0) first2 = j;
      if (clk_en[0] && clk_en[2]) begin
        n_both++;
        if (first_both == 0) first_both = j;
      end
    end
    check("sync_first_ch0", 32'(first0),     32'd3);
    check("sync_first_ch2", 32'(first2),     32'd4);
    check("sync_coincide",  32'(first_both), 32'd12);
    check("sync_n_both",    32'(n_both),     32'd2);

    // A request taken together with sync loads at the first wrap after sync.
    // ch4 runs at ratio 2, so that wrap comes 2 cycles after the sync edge.
    wait_ready();
    cfg_valid = 1'b1;
    cfg_ch    = CHW'(4);
    cfg_div   = CW'(3);
    sync      = 1'b1;
    tick();
    cfg_valid = 1'b0;
    sync      = 1'b0;
    k = 0;
    while (!cfg_ready && k < 20) begin
      tick();
      k++;
    end
    check("sync_req_apply_delay", 32'(k), 32'd2);
    wait_lock(4);

    // Same again on ch1 (ratio 7), then reset while the request is still pending.
    wait_ready();
    cfg_valid = 1'b1;
    cfg_ch    = CHW'(1);
    cfg_div   = CW'(6);
    sync      = 1'b1;
    tick();
    cfg_valid = 1'b0;
    sync      = 1'b0;
    repeat (2) tick();
    check("pend_before_reset", 32'(cfg_ready), 32'd0);
    do_reset("midreset");
    repeat (6) tick();
    check("post_reset_locked", 32'(locked), 32'h1f);

    // Ratio 1 on ch3: strobe held high, wave held low.
    send_cfg(3, 1);
    wait_lock(3);
    repeat (3) begin
      tick();
      check("div1_en",  32'(clk_en[3]),  32'd1);
      check("div1_out", 32'(clk_out[3]), 32'd0);
    end

    // Random traffic, checked every cycle against the model.
    for (int j = 0; j < 1500; j++) begin
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = CHW'($urandom_range(0, 7));
      cfg_div   = CW'($urandom_range(0, 9));
      sync      = ($urandom_range(0, 39) == 0);
      tick();
    end
    cfg_valid = 1'b0;
    sync      = 1'b0;
    do_reset("final");
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
